uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command sequencer that sits behind the UART byte receiver and turns its byte stream into register-bus transactions. It detects each newly accepted byte, then assembles a fixed 5-byte frame: header, cmd, addr, data, checksum. It validates the frame, issues one held-until-ack write or read on the bus, and hands read data to the TX side via a valid/ready response port. It also flags checksum, command, inter-byte timeout and overrun errors.

Parameters:
HEADER, 8'hA5, frame start byte
CMD_WR, 8'h01, write command code
CMD_RD, 8'h02, read command code
TO_W, 16, width of inter-byte gap counter
TIMEOUT_CYCLES, 16'd50000, max clk_i cycles between bytes inside a frame

Ports:
clk_i  in  1  system clock; single clock domain
rst_ni  in  1  reset; asynchronous, active-low
rx_data_i  in  8  received byte from UART receiver
rx_accept_i  in  1  receiver accept level; held high after a good stop bit until the next start bit
bus_addr_o  out  8  register address
bus_wdata_o  out  8  write data
bus_wr_o  out  1  write request, held until ack
bus_rd_o  out  1  read request, held until ack
bus_ack_i  in  1  bus acknowledge, single-cycle
bus_rdata_i  in  8  read data, sampled when bus_ack_i=1
resp_data_o  out  8  read response byte
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumer ready
err_csum_o  out  1  1-cycle pulse: checksum mismatch
err_cmd_o  out  1  1-cycle pulse: unknown cmd with good checksum
err_timeout_o  out  1  1-cycle pulse: inter-byte timeout
err_overrun_o  out  1  1-cycle pulse: byte arrived while busy
busy_o  out  1  high in any state other than HUNT

Behaviour:
- Reset (rst_ni=0, asynchronous): state=HUNT, all outputs 0, timer=0, accept_q=1. accept_q=1 blocks a spurious byte event if rx_accept_i is high at release.
- byte_evt = rx_accept_i & ~accept_q. accept_q is a register copy of rx_accept_i. rx_data_i is sampled in the byte_evt cycle.
- States: HUNT, CMD, ADDR, DATA, CSUM, BUS, RESP.
- HUNT: byte_evt with rx_data_i==HEADER goes to CMD. Any other byte is ignored with no error.
- CMD, ADDR, DATA: byte_evt latches cmd_q, addr_q, data_q respectively and advances one state. A read frame still carries a data byte, which is ignored.
- CSUM: on byte_evt, compare rx_data_i against cmd_q^addr_q^data_q.
  - Mismatch: err_csum_o pulse, go to HUNT. A mismatch takes priority over a bad cmd.
  - Match with cmd_q not CMD_WR/CMD_RD: err_cmd_o pulse, go to HUNT.
  - Match with valid cmd: go to BUS.
- Timeout: the timer clears on every byte_evt and in HUNT, and counts in CMD..CSUM. When timer==TIMEOUT_CYCLES-1 with no byte_evt: err_timeout_o pulse, go to HUNT. If byte_evt and expiry fall in the same cycle, the byte wins.
- BUS:
  - bus_wr_o or bus_rd_o is registered high in the cycle after the checksum byte_evt.
  - bus_addr_o and bus_wdata_o are stable for the whole request.
  - There is no timeout while waiting for ack.
  - On bus_ack_i for a write: drop the request next cycle, go to HUNT.
  - On bus_ack_i for a read: latch bus_rdata_i into resp_data_o; next cycle bus_rd_o=0 and resp_valid_o=1; go to RESP.
- RESP: resp_valid_o stays high and resp_data_o stays stable until resp_ready_i=1. The handshake cycle returns to HUNT, with resp_valid_o=0 next cycle.
- byte_evt in BUS or RESP: the byte is dropped and err_overrun_o pulses. The state is unchanged.
- bus_ack_i outside BUS is ignored.
- All error pulses are registered and last exactly 1 cycle. At most one error fires per cycle.
- Latency: checksum byte_evt at cycle N gives a bus request at N+1. Read ack at M gives resp_valid_o at M+1.

Decomposition:
- Package uart_ctrl_pkg holds:
  - the state enum;
  - HEADER, CMD_WR and CMD_RD defaults;
  - FRAME_LEN=5.
- One sub-module, uart_gap_timer, is natural. Inputs: clear, enable. Output: expire pulse. Parameters: TO_W, TIMEOUT_CYCLES.
- The edge detect and FSM stay in the top level.

Test Plan:
1. Write frame A5 01 10 3C 2D, ack 3 cycles later → bus_wr_o=1 with addr=0x10, wdata=0x3C from csum_evt+1 until ack; no resp_valid_o; busy_o=0 after.
2. Read frame A5 02 20 00 22, ack with rdata=0x5A, resp_ready_i low 4 cycles → resp_valid_o=1, resp_data_o=0x5A held 4 cycles, cleared after ready.
3. Garbage 00 FF then A5 01 10 3C 00 → prefix ignored, err_csum_o single pulse, no bus request, back to HUNT.
4. A5 07 00 00 07 → err_cmd_o pulse, no bus request. Separately, A5 01 then silence → err_timeout_o exactly TIMEOUT_CYCLES cycles after the 01 byte_evt; a following valid frame still completes.
5. Byte event during BUS wait and during RESP → err_overrun_o pulse each, addr/wdata/resp_data unchanged. Then assert rst_ni=0 mid-frame (after ADDR) → immediate HUNT, all outputs 0, no spurious byte_evt with rx_accept_i high at release.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART command sequencer.
// The frame is header, cmd, addr, data, checksum, where checksum = cmd ^ addr ^ data.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      S_HUNT,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_CSUM,
      S_BUS,
      S_RESP
   } state_e;

   localparam logic [7:0] HEADER_DEF = 8'hA5;
   localparam logic [7:0] CMD_WR_DEF = 8'h01;
   localparam logic [7:0] CMD_RD_DEF = 8'h02;
   localparam int         FRAME_LEN  = 5;

   function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
      return cmd ^ addr ^ data;
   endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap watchdog.
// expire is combinational and fires on the last allowed cycle unless clear wins that cycle.
module uart_gap_timer #(
   parameter int              TO_W           = 16,
   parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [TO_W-1:0] cnt_q;

   assign expire = enable && !clear && (cnt_q == TIMEOUT_CYCLES - 1'b1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else if (clear)
         cnt_q <= '0;
      else if (enable)
         cnt_q <= cnt_q + 1'b1;
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Turns the UART receiver byte stream into single register-bus transactions.
// Every output is a register; the comb process computes next values only.
module uart_cmd_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter logic [7:0]      HEADER         = HEADER_DEF,
   parameter logic [7:0]      CMD_WR         = CMD_WR_DEF,
   parameter logic [7:0]      CMD_RD         = CMD_RD_DEF,
   parameter int              TO_W           = 16,
   parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] rx_data_i,
   input  logic       rx_accept_i,
   output logic [7:0] bus_addr_o,
   output logic [7:0] bus_wdata_o,
   output logic       bus_wr_o,
   output logic       bus_rd_o,
   input  logic       bus_ack_i,
   input  logic [7:0] bus_rdata_i,
   output logic [7:0] resp_data_o,
   output logic       resp_valid_o,
   input  logic       resp_ready_i,
   output logic       err_csum_o,
   output logic       err_cmd_o,
   output logic       err_timeout_o,
   output logic       err_overrun_o,
   output logic       busy_o
);

   state_e     state_q, state_d;
   logic       accept_q, byte_evt;
   logic [7:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d, resp_q, resp_d;
   logic       wr_q, wr_d, rd_q, rd_d, vld_q, vld_d;
   logic       e_csum_q, e_csum_d, e_cmd_q, e_cmd_d;
   logic       e_to_q, e_to_d, e_ovr_q, e_ovr_d;
   logic       tmr_clear, tmr_en, tmr_expire;

   // accept_q resets high so a level already present at reset release is not a new byte
   assign byte_evt  = rx_accept_i & ~accept_q;
   assign tmr_clear = byte_evt | (state_q == S_HUNT);
   assign tmr_en    = state_q inside {S_CMD, S_ADDR, S_DATA, S_CSUM};

   uart_gap_timer #(
      .TO_W           (TO_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear  (tmr_clear),
      .enable (tmr_en),
      .expire (tmr_expire)
   );

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      data_d   = data_q;
      resp_d   = resp_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      vld_d    = vld_q;
      e_csum_d = 1'b0;
      e_cmd_d  = 1'b0;
      e_to_d   = 1'b0;
      e_ovr_d  = 1'b0;
      case (state_q)
         S_HUNT:
            if (byte_evt && rx_data_i == HEADER) state_d = S_CMD;
         S_CMD:
            if (byte_evt) begin
               cmd_d   = rx_data_i;
               state_d = S_ADDR;
            end
         S_ADDR:
            if (byte_evt) begin
               addr_d  = rx_data_i;
               state_d = S_DATA;
            end
         S_DATA:
            if (byte_evt) begin
               data_d  = rx_data_i;
               state_d = S_CSUM;
            end
         S_CSUM:
            if (byte_evt) begin
               // a bad checksum is reported even when the cmd is also bad
               if (rx_data_i != frame_csum(cmd_q, addr_q, data_q)) begin
                  e_csum_d = 1'b1;
                  state_d  = S_HUNT;
               end else if (cmd_q == CMD_WR) begin
                  wr_d    = 1'b1;
                  state_d = S_BUS;
               end else if (cmd_q == CMD_RD) begin
                  rd_d    = 1'b1;
                  state_d = S_BUS;
               end else begin
                  e_cmd_d = 1'b1;
                  state_d = S_HUNT;
               end
            end
         S_BUS: begin
            e_ovr_d = byte_evt;
            if (bus_ack_i) begin
               wr_d = 1'b0;
               rd_d = 1'b0;
               if (rd_q) begin
                  resp_d  = bus_rdata_i;
                  vld_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_HUNT;
               end
            end
         end
         S_RESP: begin
            e_ovr_d = byte_evt;
            if (resp_ready_i) begin
               vld_d   = 1'b0;
               state_d = S_HUNT;
            end
         end
         default: state_d = S_HUNT;
      endcase
      // expire already excludes a same-cycle byte, so the byte wins
      if (tmr_expire) begin
         e_to_d  = 1'b1;
         state_d = S_HUNT;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_HUNT;
         accept_q <= 1'b1;
         cmd_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         resp_q   <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         vld_q    <= 1'b0;
         e_csum_q <= 1'b0;
         e_cmd_q  <= 1'b0;
         e_to_q   <= 1'b0;
         e_ovr_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         accept_q <= rx_accept_i;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         resp_q   <= resp_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         vld_q    <= vld_d;
         e_csum_q <= e_csum_d;
         e_cmd_q  <= e_cmd_d;
         e_to_q   <= e_to_d;
         e_ovr_q  <= e_ovr_d;
      end
   end

   assign bus_addr_o    = addr_q;
   assign bus_wdata_o   = data_q;
   assign bus_wr_o      = wr_q;
   assign bus_rd_o      = rd_q;
   assign resp_data_o   = resp_q;
   assign resp_valid_o  = vld_q;
   assign err_csum_o    = e_csum_q;
   assign err_cmd_o     = e_cmd_q;
   assign err_timeout_o = e_to_q;
   assign err_overrun_o = e_ovr_q;
   assign busy_o        = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame table, hand-written timing/overrun/reset sequences,
// and random frames scored against a frame-level model of the protocol.
module tb_uart_cmd_ctrl;
   import uart_ctrl_pkg::*;

   localparam logic [15:0] TO = 16'd64;
   localparam int K_WR = 0, K_RD = 1, K_CSUM = 2, K_CMD = 3;

   logic       clk, rst_ni;
   logic [7:0] rx_data_i;
   logic       rx_accept_i;
   logic [7:0] bus_addr_o, bus_wdata_o, bus_rdata_i, resp_data_o;
   logic       bus_wr_o, bus_rd_o, bus_ack_i, resp_valid_o, resp_ready_i;
   logic       err_csum_o, err_cmd_o, err_timeout_o, err_overrun_o, busy_o;

   uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .rx_data_i(rx_data_i), .rx_accept_i(rx_accept_i),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wr_o(bus_wr_o),
      .bus_rd_o(bus_rd_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .resp_data_o(resp_data_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .err_csum_o(err_csum_o), .err_cmd_o(err_cmd_o), .err_timeout_o(err_timeout_o),
      .err_overrun_o(err_overrun_o), .busy_o(busy_o)
   );

   typedef struct {
      logic [15:0] pre;
      int          npre;
      logic [39:0] frm;
      int          kind;
      logic [7:0]  rdv;
      int          ackd;
   } vec_t;

   vec_t tbl[6];
   int nvec = 0, nfail = 0, cyc = 0;
   int evt_cyc, csum_cyc, req_rise, req_fall, ack_cyc, vld_rise, to_cyc;
   int ack_dly = 0;
   logic [7:0] rd_val = 0;
   logic rdy_rand = 1'b1, rdy_fix = 1'b0;
   logic [17:0] obs_bus[$];
   logic [7:0]  obs_resp[$];
   int          obs_err[$];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", nvec);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Bus slave: ack after ack_dly request cycles; response consumer: fixed or random ready
   initial begin
      int acnt = 0;
      bus_ack_i = 0; bus_rdata_i = 0; resp_ready_i = 0;
      forever begin
         @(posedge clk); #1;
         bus_rdata_i = 8'($urandom);
         if (bus_ack_i) bus_ack_i = 0;
         else if (rst_ni && (bus_wr_o || bus_rd_o)) begin
            if (acnt >= ack_dly) begin
               bus_ack_i = 1; bus_rdata_i = rd_val; acnt = 0;
            end else acnt++;
         end
         resp_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
      end
   end

   // Monitor: logs transactions and errors, checks stability and pulse width
   initial begin
      logic preq = 0, pvld = 0, perr = 0;
      logic [7:0] pa = 0, pd = 0, pr = 0;
      forever begin
         @(negedge clk);
         if (rst_ni) begin
            if ((bus_wr_o || bus_rd_o) && !preq) begin
               obs_bus.push_back({bus_rd_o, bus_wr_o, bus_addr_o, bus_wdata_o});
               req_rise = cyc;
            end
            if ((bus_wr_o || bus_rd_o) && preq) chk("req_stable", {bus_addr_o, bus_wdata_o}, {pa, pd});
            if (!(bus_wr_o || bus_rd_o) && preq) req_fall = cyc;
            if (bus_ack_i && (bus_wr_o || bus_rd_o)) ack_cyc = cyc;
            if (resp_valid_o && !pvld) vld_rise = cyc;
            if (resp_valid_o && pvld) chk("resp_stable", resp_data_o, pr);
            if (resp_valid_o && resp_ready_i) obs_resp.push_back(resp_data_o);
            if (err_csum_o + err_cmd_o + err_timeout_o + err_overrun_o > 1)
               chk("one_err", err_csum_o + err_cmd_o + err_timeout_o + err_overrun_o, 1);
            if (perr) chk("err_1cyc", {err_csum_o, err_cmd_o, err_timeout_o, err_overrun_o}, 0);
            if (err_csum_o) obs_err.push_back(1);
            if (err_cmd_o) obs_err.push_back(2);
            if (err_timeout_o) begin obs_err.push_back(3); to_cyc = cyc; end
            if (err_overrun_o) obs_err.push_back(4);
         end
         preq = bus_wr_o || bus_rd_o; pvld = resp_valid_o;
         perr = err_csum_o | err_cmd_o | err_timeout_o | err_overrun_o;
         pa = bus_addr_o; pd = bus_wdata_o; pr = resp_data_o;
      end
   end

   // One receiver byte: accept rises for a cycle, then stays low gap cycles
   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      rx_data_i = b; rx_accept_i = 1; evt_cyc = cyc;
      @(posedge clk); #1;
      rx_accept_i = 0; rx_data_i = 8'($urandom);
      repeat (gap - 1) @(posedge clk);
   endtask

   task automatic send_frame(input logic [39:0] f);
      for (int i = 0; i < FRAME_LEN; i++) send_byte(f[39-8*i -: 8], $urandom_range(1, 6));
      csum_cyc = evt_cyc;
   endtask

   task automatic clear_obs();
      obs_bus.delete(); obs_resp.delete(); obs_err.delete();
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end while (busy_o && n < 400);
      if (busy_o) chk("idle_wait", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid();
      int n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid_o && n < 200);
      chk("valid_seen", resp_valid_o, 1);
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, {bus_addr_o, bus_wdata_o, bus_wr_o, bus_rd_o, resp_data_o, resp_valid_o,
               err_csum_o, err_cmd_o, err_timeout_o, err_overrun_o, busy_o}, 0);
   endtask

   // Frame-level rules: checksum first, then the command code decides
   function automatic int model_kind(input logic [39:0] f);
      logic [7:0] c, a, d, s;
      c = f[31:24]; a = f[23:16]; d = f[15:8]; s = f[7:0];
      if (s != (c ^ a ^ d)) return K_CSUM;
      if (c == 8'h01) return K_WR;
      if (c == 8'h02) return K_RD;
      return K_CMD;
   endfunction

   task automatic expect_outcome(input int kind, input logic [7:0] a, input logic [7:0] d,
                                 input logic [7:0] rv);
      logic txn;
      txn = (kind == K_WR || kind == K_RD);
      wait_idle();
      chk("bus_cnt", obs_bus.size(), txn);
      if (txn && obs_bus.size() > 0) begin
         chk("bus_txn", obs_bus[0], {kind == K_RD, kind == K_WR, a, d});
         chk("req_lat", req_rise, csum_cyc + 1);
         chk("req_drop", req_fall, ack_cyc + 1);
         if (kind == K_RD) chk("resp_lat", vld_rise, ack_cyc + 1);
      end
      chk("resp_cnt", obs_resp.size(), kind == K_RD);
      if (kind == K_RD && obs_resp.size() > 0) chk("resp_data", obs_resp[0], rv);
      chk("err_cnt", obs_err.size(), !txn);
      if (!txn && obs_err.size() > 0) chk("err_kind", obs_err[0], kind == K_CSUM ? 1 : 2);
      chk("idle_busy", busy_o, 0);
      clear_obs();
   endtask

   task automatic run_vec(input vec_t v);
      ack_dly = v.ackd; rd_val = v.rdv;
      for (int i = 0; i < v.npre; i++) send_byte(v.pre[15-8*i -: 8], $urandom_range(1, 6));
      send_frame(v.frm);
      expect_outcome(v.kind, v.frm[23:16], v.frm[15:8], v.rdv);
   endtask

   initial begin
      vec_t v;
      logic [7:0] c, a, d, s, g;
      rst_ni = 0; rx_accept_i = 0; rx_data_i = 0;
      tbl[0] = '{16'h0000, 0, 40'hA5_01_10_3C_2D, K_WR,   8'h00, 3};
      tbl[1] = '{16'h0000, 0, 40'hA5_02_20_00_22, K_RD,   8'h5A, 1};
      tbl[2] = '{16'h00FF, 2, 40'hA5_01_10_3C_00, K_CSUM, 8'h00, 0};
      tbl[3] = '{16'h0000, 0, 40'hA5_07_00_00_07, K_CMD,  8'h00, 0};
      tbl[4] = '{16'h0000, 0, 40'hA5_02_7F_99_E4, K_RD,   8'hC3, 0};
      tbl[5] = '{16'h0000, 0, 40'hA5_07_00_00_06, K_CSUM, 8'h00, 0};

      repeat (3) @(posedge clk); #1;
      chk_zero("reset_outs");
      rst_ni = 1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // read response held while the consumer stalls
      rdy_rand = 0; rdy_fix = 0; ack_dly = 2; rd_val = 8'h5A;
      send_frame(40'hA5_02_20_00_22);
      wait_valid();
      for (int i = 0; i < 4; i++) begin
         chk("hold_valid", resp_valid_o, 1);
         chk("hold_data", resp_data_o, 8'h5A);
         if (i < 3) @(negedge clk);
      end
      rdy_fix = 1;
      @(negedge clk); chk("hs_valid", resp_valid_o, 1);
      @(negedge clk); chk("post_hs_valid", resp_valid_o, 0);
      expect_outcome(K_RD, 8'h20, 8'h00, 8'h5A);
      rdy_fix = 0; rdy_rand = 1;

      // silence after cmd: expiry detected TO cycles after the byte, pulse registered one later
      send_byte(8'hA5, 2);
      send_byte(8'h01, int'(TO) + 4);
      chk("to_err_cnt", obs_err.size(), 1);
      if (obs_err.size() > 0) chk("to_err_kind", obs_err[0], 3);
      chk("to_lat", to_cyc, evt_cyc + int'(TO) + 1);
      chk("to_busy", busy_o, 0);
      clear_obs();
      run_vec(tbl[0]);

      // byte landing exactly on the expiry cycle wins
      ack_dly = 0;
      send_byte(8'hA5, 2);
      send_byte(8'h01, int'(TO) - 1);
      send_byte(8'h10, 2);
      send_byte(8'h3C, 2);
      send_byte(8'h2D, 2);
      csum_cyc = evt_cyc;
      expect_outcome(K_WR, 8'h10, 8'h3C, 8'h00);

      // overrun while waiting for write ack
      ack_dly = 20;
      send_frame(40'hA5_01_44_55_10);
      send_byte(8'h33, 2);
      repeat (2) @(negedge clk);
      chk("ovr_wr_cnt", obs_err.size(), 1);
      if (obs_err.size() > 0) chk("ovr_wr_kind", obs_err[0], 4);
      chk("ovr_wr_req", {bus_wr_o, bus_addr_o, bus_wdata_o}, {1'b1, 8'h44, 8'h55});
      obs_err.delete();
      expect_outcome(K_WR, 8'h44, 8'h55, 8'h00);

      // overrun while a read response is pending
      rdy_rand = 0; rdy_fix = 0; ack_dly = 0; rd_val = 8'h96;
      send_frame(40'hA5_02_30_00_32);
      wait_valid();
      send_byte(8'hA5, 2);
      repeat (2) @(negedge clk);
      chk("ovr_rd_cnt", obs_err.size(), 1);
      if (obs_err.size() > 0) chk("ovr_rd_kind", obs_err[0], 4);
      chk("ovr_rd_resp", {resp_valid_o, resp_data_o}, {1'b1, 8'h96});
      obs_err.delete();
      rdy_fix = 1;
      expect_outcome(K_RD, 8'h30, 8'h00, 8'h96);
      rdy_fix = 0; rdy_rand = 1;

      // reset mid-frame, released with accept high and a header byte on the wire
      send_byte(8'hA5, 2); send_byte(8'h01, 2); send_byte(8'h20, 2);
      @(posedge clk); #1;
      rst_ni = 0; #1;
      chk_zero("midreset_outs");
      rx_accept_i = 1; rx_data_i = 8'hA5;
      repeat (2) @(posedge clk); #1;
      rst_ni = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("release_busy", busy_o, 0);
      end
      rx_accept_i = 0;
      chk("release_errs", obs_err.size(), 0);
      clear_obs();
      run_vec(tbl[0]);

      // random frames against the frame-level model
      for (int n = 0; n < 40; n++) begin
         v.npre = $urandom_range(0, 2);
         for (int i = 0; i < 2; i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h00;
            v.pre[15-8*i -: 8] = g;
         end
         case ($urandom_range(0, 3))
            0, 1:    c = 8'h01;
            2:       c = 8'h02;
            default: c = 8'($urandom);
         endcase
         a = 8'($urandom); d = 8'($urandom);
         s = c ^ a ^ d;
         if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
         v.frm  = {8'hA5, c, a, d, s};
         v.kind = model_kind(v.frm);
         v.rdv  = 8'($urandom);
         v.ackd = $urandom_range(0, 4);
         run_vec(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
